// File: rtl/word_sprite_reader_if.sv
// Pixel-side bus of word_sprite_reader: VGA coordinate in, ROM row out/in,
// and the lit-pixel result towards the colour mux.
// master: the VGA/ROM side that drives coordinates and returns ROM rows.
// slave:  word_sprite_reader itself.
interface word_sprite_reader_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_tick;
  logic        enable;
  logic [4:0]  rom_addr;
  logic [63:0] rom_data;
  logic        pix_on;
  logic [11:0] rgb;

  modport master (
    output pixel_x, pixel_y, video_on, frame_tick, enable, rom_data,
    input  rom_addr, pix_on, rgb
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_tick, enable, rom_data,
    output rom_addr, pix_on, rgb
  );
endinterface

// File: rtl/word_sprite_reader.sv
// word_sprite_reader: two-stage pipelined reader for the 32x64 word bitmap ROM.
// Stage 1 decides whether the pixel lies inside the word box and registers the
// ROM row address, the column index and a valid flag. Stage 2 picks the column
// bit out of the (combinational) ROM row and registers pix_on / rgb.
// Optional blinking is compiled in with the macro WORD_BLINK_EN.
module word_sprite_reader #(
  parameter int          X0           = 288,
  parameter int          Y0           = 224,
  parameter int          SCALE_LOG2   = 0,
  parameter logic [11:0] COLOR        = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input logic                 clk,
  input logic                 reset,
  word_sprite_reader_if.slave bus
);

  // Box bounds are held one bit wider than the coordinates so that the
  // exclusive right/bottom edge never wraps for boxes touching column 1023.
  localparam logic [10:0] X_LO   = 11'(X0);
  localparam logic [10:0] X_HI   = 11'(X0 + (64 << SCALE_LOG2));
  localparam logic [10:0] Y_LO   = 11'(Y0);
  localparam logic [10:0] Y_HI   = 11'(Y0 + (32 << SCALE_LOG2));
  localparam logic [9:0]  X_BASE = 10'(X0);
  localparam logic [9:0]  Y_BASE = 10'(Y0);

  logic       in_box;
  logic [9:0] dx;
  logic [9:0] dy;
  logic [5:0] col_d;
  logic [4:0] row_d;
  logic [5:0] col_q;
  logic       vld_q;
  logic       show;
  logic       lit;

  // Box test and box-relative row/column; offsets are only used inside the box.
  always_comb begin
    in_box = ({1'b0, bus.pixel_x} >= X_LO) && ({1'b0, bus.pixel_x} < X_HI) &&
             ({1'b0, bus.pixel_y} >= Y_LO) && ({1'b0, bus.pixel_y} < Y_HI);
    dx     = bus.pixel_x - X_BASE;
    dy     = bus.pixel_y - Y_BASE;
    col_d  = 6'(dx >> SCALE_LOG2);
    row_d  = 5'(dy >> SCALE_LOG2);
  end

  // Stage 1: register ROM row address, column and the gated valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_addr <= '0;
      col_q        <= '0;
      vld_q        <= 1'b0;
    end else begin
      bus.rom_addr <= in_box ? row_d : 5'd0;
      col_q        <= in_box ? col_d : 6'd0;
      vld_q        <= in_box & bus.video_on & bus.enable;
    end
  end

  // Column 0 is the leftmost pixel and lives in the MSB of the ROM row.
  always_comb begin
    lit = vld_q & bus.rom_data[6'd63 - col_q] & show;
  end

  // Stage 2: register the lit flag and its colour for the pixel mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pix_on <= 1'b0;
      bus.rgb    <= '0;
    end else begin
      bus.pix_on <= lit;
      bus.rgb    <= lit ? COLOR : 12'h000;
    end
  end

`ifdef WORD_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt;

  // Frame counter: toggles show every BLINK_FRAMES frame ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      show <= 1'b1;
    end else if (bus.frame_tick) begin
      if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt  <= '0;
        show <= ~show;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_frame_tick;

  assign show              = 1'b1;
  assign unused_frame_tick = bus.frame_tick;
`endif

endmodule

// File: tb/tb_word_sprite_reader.sv
// Testbench for word_sprite_reader. A local ROM image with known bits at the
// interesting coordinates is served combinationally from rom_addr. Expected
// results are queued when each pixel is driven and compared when the pipeline
// delivers them (rom_addr one clock later, pix_on/rgb two clocks later).
module tb_word_sprite_reader;

  localparam int          X0     = 288;
  localparam int          Y0     = 224;
  localparam int          S      = 0;
  localparam logic [11:0] COLOR  = 12'hFFF;
  localparam int          BLINKF = 2;

  logic clk = 1'b0;
  logic reset;

  word_sprite_reader_if bus ();

  word_sprite_reader #(
    .X0(X0), .Y0(Y0), .SCALE_LOG2(S), .COLOR(COLOR), .BLINK_FRAMES(BLINKF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [63:0] romMem [32];

  assign bus.rom_data = romMem[bus.rom_addr];

  typedef struct {
    int         issue;
    logic [4:0] addr;
    bit         pix;
    string      tag;
  } exp_t;

  typedef struct {
    int         x;
    int         y;
    bit         vo;
    bit         en;
    logic [4:0] addr;
    bit         pix;
    string      tag;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   cntM = 0;
  bit   showM = 1'b1;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic checkOutput(input bit rstEdge);
    exp_t e;
    bit   ep;
    foreach (sb[i]) begin
      if (sb[i].issue + 1 == cycle)
        checkValue({sb[i].tag, ".addr"}, 32'(bus.rom_addr), 32'(sb[i].addr));
    end
    while (sb.size() > 0 && sb[0].issue + 2 == cycle) begin
      e  = sb.pop_front();
      ep = rstEdge ? 1'b0 : e.pix;
      checkValue({e.tag, ".pix"}, 32'(bus.pix_on), 32'(ep));
      checkValue({e.tag, ".rgb"}, 32'(bus.rgb), ep ? 32'(COLOR) : 32'h0);
    end
  endtask

  task automatic tick();
    bit rstEdge;
    rstEdge = reset;
    @(posedge clk);
    #1;
    cycle++;
    checkOutput(rstEdge);
  endtask

  // Drives one pixel for one clock. With useTab the expectation comes from the
  // caller, otherwise from the reference model below.
  task automatic applyStimulus(input int x, input int y, input bit vo, input bit en,
                               input bit tk, input bit rst, input bit useTab,
                               input logic [4:0] tAddr, input bit tPix, input string tag);
    exp_t e;
    bit   inBox;
    int   row;
    int   col;
    bus.pixel_x    = 10'(x);
    bus.pixel_y    = 10'(y);
    bus.video_on   = vo;
    bus.enable     = en;
    bus.frame_tick = tk;
    reset          = rst;
`ifdef WORD_BLINK_EN
    if (rst) begin
      cntM  = 0;
      showM = 1'b1;
    end else if (tk) begin
      if (cntM == BLINKF - 1) begin
        cntM  = 0;
        showM = !showM;
      end else begin
        cntM++;
      end
    end
`endif
    e.issue = cycle;
    e.tag   = tag;
    if (useTab) begin
      e.addr = tAddr;
      e.pix  = tPix;
    end else begin
      inBox = (x >= X0) && (x < X0 + (64 << S)) && (y >= Y0) && (y < Y0 + (32 << S));
      row   = inBox ? ((y - Y0) >> S) : 0;
      col   = inBox ? ((x - X0) >> S) : 0;
      e.addr = rst ? 5'd0 : 5'(row);
      e.pix  = !rst && inBox && vo && en && romMem[row][63 - col] && showM;
    end
    sb.push_back(e);
    tick();
  endtask

  initial begin
    // Known ROM image: pseudo-random rows with bits pinned where checked.
    for (int r = 0; r < 32; r++)
      romMem[r] = 64'h0123_4567_89AB_CDEF ^ (64'(r) * 64'h9E37_79B9_7F4A_7C15);
    romMem[0][63 - 0]  = 1'b0;
    romMem[0][63 - 1]  = 1'b1;
    romMem[0][63 - 63] = 1'b1;
    romMem[5][63 - 15] = 1'b1;
    romMem[5][63 - 16] = 1'b0;
    romMem[31][63 - 0] = 1'b1;
    romMem[31][63 - 63] = 1'b0;

    vecs[0]  = '{288, 224, 1'b1, 1'b1, 5'd0,  1'b0, "topLeft"};
    vecs[1]  = '{289, 224, 1'b1, 1'b1, 5'd0,  1'b1, "topLeftP1"};
    vecs[2]  = '{303, 229, 1'b1, 1'b1, 5'd5,  1'b1, "row5col15"};
    vecs[3]  = '{304, 229, 1'b1, 1'b1, 5'd5,  1'b0, "row5col16"};
    vecs[4]  = '{287, 230, 1'b1, 1'b1, 5'd0,  1'b0, "leftOut"};
    vecs[5]  = '{352, 230, 1'b1, 1'b1, 5'd0,  1'b0, "rightOut"};
    vecs[6]  = '{300, 223, 1'b1, 1'b1, 5'd0,  1'b0, "topOut"};
    vecs[7]  = '{300, 256, 1'b1, 1'b1, 5'd0,  1'b0, "bottomOut"};
    vecs[8]  = '{351, 255, 1'b1, 1'b1, 5'd31, 1'b0, "bottomRight"};
    vecs[9]  = '{351, 224, 1'b1, 1'b1, 5'd0,  1'b1, "topRight"};
    vecs[10] = '{288, 255, 1'b1, 1'b1, 5'd31, 1'b1, "bottomLeft"};
    vecs[11] = '{289, 224, 1'b0, 1'b1, 5'd0,  1'b0, "videoOff"};
    vecs[12] = '{289, 224, 1'b1, 1'b0, 5'd0,  1'b0, "enableOff"};

    bus.pixel_x = '0;
    bus.pixel_y = '0;
    bus.video_on = 1'b0;
    bus.enable = 1'b0;
    bus.frame_tick = 1'b0;
    reset = 1'b1;
    tick();

    // Reset held two clocks on a lit in-box pixel: outputs stay cleared.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(289, 224, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, "inReset");
      checkValue("resetPix", 32'(bus.pix_on), 32'h0);
      checkValue("resetRgb", 32'(bus.rgb), 32'h0);
      checkValue("resetAddr", 32'(bus.rom_addr), 32'h0);
    end
    applyStimulus(289, 224, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "afterReset");

    // Table-driven coordinate and gating vectors.
    foreach (vecs[i])
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].vo, vecs[i].en, 1'b0, 1'b0,
                    1'b1, vecs[i].addr, vecs[i].pix, vecs[i].tag);

    // Per-cycle toggling of video_on and enable on a lit pixel.
    for (int i = 0; i < 8; i++)
      applyStimulus(289, 224, i[0], i[1], 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "gateToggle");

    // Reset pulse in the middle of a scan line.
    for (int i = 0; i < 10; i++)
      applyStimulus(289 + i, 224, 1'b1, 1'b1, 1'b0, (i == 4), 1'b0, 5'd0, 1'b0, "midLineReset");

    // Random pixels around the box.
    for (int i = 0; i < 200; i++)
      applyStimulus(int'($urandom_range(360, 280)), int'($urandom_range(262, 218)),
                    ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                    1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "random");

    // Frame ticks on a held lit pixel, including a reset mid-count.
    for (int i = 0; i < 24; i++)
      applyStimulus(289, 224, 1'b1, 1'b1, (i % 3 == 1) || (i == 15), (i == 14),
                    1'b0, 5'd0, 1'b0, "blink");

    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
